// File: rtl/ahb_lite_pkg.sv
// ---------------------------------------------------------------------------
// ahb_lite_pkg
// Shared AHB-lite encodings and the register-bank slave FSM state type.
//   htrans_e    : IDLE / BUSY / NONSEQ / SEQ transfer types
//   hresp_e     : OKAY / ERROR response codes
//   hsize_e     : transfer size encodings (byte .. dword)
//   slv_state_e : slave data-phase FSM states
// ---------------------------------------------------------------------------
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } slv_state_e;

endpackage

// File: rtl/ahb_wstrb_gen.sv
// ---------------------------------------------------------------------------
// ahb_wstrb_gen
// Combinational byte-strobe generator for an AHB data bus.
//   i_hsize    : transfer size (bytes = 2**i_hsize)
//   i_addr     : low address bits selecting the starting byte lane
//   o_strb     : one bit per byte lane touched by the transfer
//   o_misalign : address not aligned to the transfer size
// Oversized transfers are not flagged here; the caller checks hsize.
// ---------------------------------------------------------------------------
module ahb_wstrb_gen
  import ahb_lite_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned NB         = DATA_WIDTH / 8,
  localparam int unsigned B          = $clog2(NB)
) (
  input  logic [2:0]    i_hsize,
  input  logic [B-1:0]  i_addr,
  output logic [NB-1:0] o_strb,
  output logic          o_misalign
);

  int unsigned w_bytes;
  int unsigned w_off;

  always_comb begin
    w_bytes    = 32'd1 << i_hsize;
    w_off      = 32'(i_addr);
    o_misalign = (w_off & (w_bytes - 32'd1)) != 32'd0;
    o_strb     = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if ((i >= w_off) && (i < w_off + w_bytes)) o_strb[i] = 1'b1;
    end
  end

endmodule

// File: rtl/ahb_regbank_slave.sv
// ---------------------------------------------------------------------------
// ahb_regbank_slave
// AHB-lite register bank with byte-lane writes, read-only mask, programmable
// wait states and a two-cycle ERROR response. All registers are exported
// flat on regs_o for the monitoring logic.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   hsel_i .. hmastlock_i : AHB-lite slave inputs (hburst/hmastlock ignored)
//   hreadyo_o, hresp_o  : transfer done / response (OKAY, ERROR)
//   hrdata_o            : read data, valid only in the completing cycle
//   regs_o              : register i at [i*DATA_WIDTH +: DATA_WIDTH]
// Build option: define AHB_REGBANK_PROT_EN to reject user-mode writes
// (hprot_i[1]==0) with an ERROR response.
// ---------------------------------------------------------------------------
module ahb_regbank_slave
  import ahb_lite_pkg::*;
#(
  parameter int unsigned          N_REGS      = 16,
  parameter int unsigned          DATA_WIDTH  = 32,
  parameter int unsigned          HADDR_WIDTH = 32,
  parameter int unsigned          WAIT_STATES = 0,
  parameter logic [N_REGS-1:0]    RO_MASK     = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         hsel_i,
  input  logic                         hreadyi_i,
  input  logic [HADDR_WIDTH-1:0]       haddr_i,
  input  logic                         hwrite_i,
  input  logic [1:0]                   htrans_i,
  input  logic [2:0]                   hsize_i,
  input  logic [2:0]                   hburst_i,
  input  logic [DATA_WIDTH-1:0]        hwdata_i,
  input  logic [3:0]                   hprot_i,
  input  logic                         hmastlock_i,
  output logic                         hreadyo_o,
  output logic [1:0]                   hresp_o,
  output logic [DATA_WIDTH-1:0]        hrdata_o,
  output logic [N_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int unsigned NB   = DATA_WIDTH / 8;
  localparam int unsigned B    = $clog2(NB);
  localparam int unsigned IDXW = $clog2(N_REGS);

  logic [DATA_WIDTH-1:0] r_regs [N_REGS];
  slv_state_e            r_state;
  hresp_e                r_hresp;
  logic                  r_hready;
  logic                  r_dphase;
  logic                  r_write;
  logic [IDXW-1:0]       r_idx;
  logic [NB-1:0]         r_strb;
  logic [3:0]            r_cnt;

  logic            w_accept;
  logic [IDXW-1:0] w_idx;
  logic [NB-1:0]   w_strb;
  logic            w_misalign;
  logic            w_err_addr;
  logic            w_err_size;
  logic            w_err_prot;
  logic            w_err;
  logic            w_complete;
  logic            w_commit;
  logic            w_unused;

  ahb_wstrb_gen #(.DATA_WIDTH(DATA_WIDTH)) u_wstrb (
    .i_hsize   (hsize_i),
    .i_addr    (haddr_i[B-1:0]),
    .o_strb    (w_strb),
    .o_misalign(w_misalign)
  );

  assign w_accept   = hsel_i & hreadyi_i & htrans_i[1];
  assign w_idx      = haddr_i[B +: IDXW];
  assign w_err_addr = (32'(w_idx) >= N_REGS) || ((haddr_i >> (B + IDXW)) != '0);
  assign w_err_size = 32'(hsize_i) > B;
`ifdef AHB_REGBANK_PROT_EN
  assign w_err_prot = hwrite_i & ~hprot_i[1];
`else
  assign w_err_prot = 1'b0;
`endif
  assign w_err      = w_err_addr | w_err_size | w_misalign | w_err_prot;
  assign w_unused   = ^{hburst_i, hmastlock_i, htrans_i[0], hprot_i};

  // hready is only low in WAIT while counting or in ERR1, so a ready cycle
  // in IDLE/WAIT with a pending data phase is the completing cycle.
  assign w_complete = ((r_state == ST_IDLE) || (r_state == ST_WAIT)) && r_hready && r_dphase;
  assign w_commit   = w_complete && r_write && !RO_MASK[r_idx];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_hready <= 1'b1;
      r_hresp  <= HRESP_OKAY;
      r_dphase <= 1'b0;
      r_write  <= 1'b0;
      r_idx    <= '0;
      r_strb   <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_WAIT: begin
          if (!r_hready) begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) r_hready <= 1'b1;
          end else begin
            r_hresp <= HRESP_OKAY;
            if (w_accept && w_err) begin
              r_state  <= ST_ERR1;
              r_hready <= 1'b0;
              r_hresp  <= HRESP_ERROR;
              r_dphase <= 1'b0;
            end else if (w_accept) begin
              r_dphase <= 1'b1;
              r_write  <= hwrite_i;
              r_idx    <= w_idx;
              r_strb   <= w_strb;
              if (WAIT_STATES > 0) begin
                r_state  <= ST_WAIT;
                r_cnt    <= 4'(WAIT_STATES);
                r_hready <= 1'b0;
              end else begin
                r_state  <= ST_IDLE;
                r_hready <= 1'b1;
              end
            end else begin
              r_state  <= ST_IDLE;
              r_dphase <= 1'b0;
              r_hready <= 1'b1;
            end
          end
        end
        ST_ERR1: begin
          r_state  <= ST_ERR2;
          r_hready <= 1'b1;
        end
        ST_ERR2: begin
          r_state  <= ST_IDLE;
          r_hresp  <= HRESP_OKAY;
          r_dphase <= 1'b0;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_hready <= 1'b1;
          r_hresp  <= HRESP_OKAY;
          r_dphase <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < N_REGS; i++) r_regs[i] <= '0;
    end else if (w_commit) begin
      for (int unsigned j = 0; j < NB; j++) begin
        if (r_strb[j]) r_regs[r_idx][j*8 +: 8] <= hwdata_i[j*8 +: 8];
      end
    end
  end

  // Read data comes straight from the array, so a read following a write
  // sees the value committed at the end of the write's data phase.
  assign hrdata_o  = (w_complete && !r_write) ? r_regs[r_idx] : '0;
  assign hreadyo_o = r_hready;
  assign hresp_o   = r_hresp;

  always_comb begin
    regs_o = '0;
    for (int unsigned i = 0; i < N_REGS; i++) regs_o[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
  end

endmodule

// File: tb/tb_ahb_regbank_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_regbank_slave
// Directed bench for ahb_regbank_slave. Two instances: u_dut0 (zero wait,
// register 1 read-only) and u_dut3 (three wait states). Each slave's
// hreadyo_o feeds its own hreadyi_i, as on a single-slave bus. Inputs change
// on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ahb_regbank_slave;

  logic         clk = 1'b0;
  logic         rst;
  logic         hsel0, hsel3;
  logic [31:0]  haddr;
  logic         hwrite;
  logic [1:0]   htrans;
  logic [2:0]   hsize;
  logic [2:0]   hburst;
  logic [31:0]  hwdata;
  logic [3:0]   hprot;
  logic         hmastlock;

  logic         hready0, hready3;
  logic [1:0]   hresp0, hresp3;
  logic [31:0]  hrdata0, hrdata3;
  logic [511:0] regs0, regs3;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_low;

  always #5 clk = ~clk;

  ahb_regbank_slave #(
    .N_REGS(16), .DATA_WIDTH(32), .HADDR_WIDTH(32), .WAIT_STATES(0), .RO_MASK(16'h0002)
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst), .hsel_i(hsel0), .hreadyi_i(hready0), .haddr_i(haddr),
    .hwrite_i(hwrite), .htrans_i(htrans), .hsize_i(hsize), .hburst_i(hburst),
    .hwdata_i(hwdata), .hprot_i(hprot), .hmastlock_i(hmastlock),
    .hreadyo_o(hready0), .hresp_o(hresp0), .hrdata_o(hrdata0), .regs_o(regs0)
  );

  ahb_regbank_slave #(
    .N_REGS(16), .DATA_WIDTH(32), .HADDR_WIDTH(32), .WAIT_STATES(3), .RO_MASK(16'h0000)
  ) u_dut3 (
    .clk_i(clk), .rst_i(rst), .hsel_i(hsel3), .hreadyi_i(hready3), .haddr_i(haddr),
    .hwrite_i(hwrite), .htrans_i(htrans), .hsize_i(hsize), .hburst_i(hburst),
    .hwdata_i(hwdata), .hprot_i(hprot), .hmastlock_i(hmastlock),
    .hreadyo_o(hready3), .hresp_o(hresp3), .hrdata_o(hrdata3), .regs_o(regs3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic s0, input logic s3, input logic [31:0] a,
                     input logic wr, input logic [2:0] sz);
    hsel0  = s0;
    hsel3  = s3;
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
    htrans = 2'b10;
  endtask

  task automatic idle();
    hsel0  = 1'b0;
    hsel3  = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; hsel0 = 1'b0; hsel3 = 1'b0; haddr = '0; hwrite = 1'b0;
    htrans = 2'b00; hsize = 3'd2; hburst = '0; hwdata = '0; hprot = 4'b0011;
    hmastlock = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hready0", 32'(hready0), 32'd1);
    chk("rst_hresp0",  32'(hresp0),  32'd0);
    chk("rst_hrdata0", hrdata0,      32'd0);
    chk("rst_hready3", 32'(hready3), 32'd1);

    // Read reg 3 after reset
    bus(1'b1, 1'b0, 32'h0C, 1'b0, 3'd2);
    @(negedge clk);
    chk("rd3_hready", 32'(hready0), 32'd1);
    chk("rd3_hresp",  32'(hresp0),  32'd0);
    chk("rd3_hrdata", hrdata0,      32'd0);

    // Word write then halfword write at byte offset 2, then read back
    bus(1'b1, 1'b0, 32'h08, 1'b1, 3'd2);
    @(negedge clk);
    chk("wr2_hready", 32'(hready0), 32'd1);
    hwdata = 32'hDEADBEEF;
    bus(1'b1, 1'b0, 32'h0A, 1'b1, 3'd1);
    @(negedge clk);
    chk("wr2h_hresp", 32'(hresp0), 32'd0);
    hwdata = 32'h1234_0000;
    bus(1'b1, 1'b0, 32'h08, 1'b0, 3'd2);
    @(negedge clk);
    hwdata = '0;
    idle();
    chk("rd2_hrdata", hrdata0, 32'h1234BEEF);
    chk("rd2_regs",   regs0[2*32 +: 32], 32'h1234BEEF);
    @(negedge clk);
    chk("idle_hrdata", hrdata0, 32'd0);

    // Byte write into lane 3 of reg 6
    bus(1'b1, 1'b0, 32'h1B, 1'b1, 3'd0);
    @(negedge clk);
    hwdata = 32'hAB00_0000;
    bus(1'b1, 1'b0, 32'h18, 1'b0, 3'd2);
    @(negedge clk);
    hwdata = '0;
    idle();
    chk("rd6_hrdata", hrdata0, 32'hAB00_0000);

    // Read-only reg 1 ignores the write but answers OKAY
    bus(1'b1, 1'b0, 32'h04, 1'b1, 3'd2);
    @(negedge clk);
    chk("ro1_hresp", 32'(hresp0), 32'd0);
    hwdata = 32'hFFFFFFFF;
    bus(1'b1, 1'b0, 32'h04, 1'b0, 3'd2);
    @(negedge clk);
    hwdata = '0;
    idle();
    chk("ro1_hrdata", hrdata0, 32'd0);
    @(negedge clk);

    // Out-of-range write: two-cycle ERROR, address phase in ERR2 ignored
    bus(1'b1, 1'b0, 32'h40, 1'b1, 3'd2);
    @(negedge clk);
    chk("oor_err1_hready", 32'(hready0), 32'd0);
    chk("oor_err1_hresp",  32'(hresp0),  32'd1);
    idle();
    hwdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("oor_err2_hready", 32'(hready0), 32'd1);
    chk("oor_err2_hresp",  32'(hresp0),  32'd1);
    chk("oor_err2_hrdata", hrdata0,      32'd0);
    bus(1'b1, 1'b0, 32'h00, 1'b1, 3'd2);
    @(negedge clk);
    idle();
    chk("oor_idle_hready", 32'(hready0), 32'd1);
    chk("oor_idle_hresp",  32'(hresp0),  32'd0);
    @(negedge clk);
    hwdata = '0;
    chk("oor_reg0",  regs0[0*32 +: 32],  32'd0);
    chk("oor_reg2",  regs0[2*32 +: 32],  32'h1234BEEF);
    chk("oor_reg15", regs0[15*32 +: 32], 32'd0);

    // Misaligned word
    bus(1'b1, 1'b0, 32'h02, 1'b0, 3'd2);
    @(negedge clk);
    idle();
    chk("mis_hresp",  32'(hresp0),  32'd1);
    chk("mis_hready", 32'(hready0), 32'd0);
    repeat (2) @(negedge clk);

    // Oversized transfer (dword on a 32-bit bus)
    bus(1'b1, 1'b0, 32'h00, 1'b0, 3'd3);
    @(negedge clk);
    idle();
    chk("size_hresp", 32'(hresp0), 32'd1);
    repeat (2) @(negedge clk);

    // Upper address bit set
    bus(1'b1, 1'b0, 32'h1000_0004, 1'b0, 3'd2);
    @(negedge clk);
    idle();
    chk("hi_hresp", 32'(hresp0), 32'd1);
    repeat (2) @(negedge clk);

    // User-mode write
    hprot = 4'b0001;
    bus(1'b1, 1'b0, 32'h1C, 1'b1, 3'd2);
    @(negedge clk);
    idle();
    hprot = 4'b0011;
    hwdata = 32'h5555AAAA;
`ifdef AHB_REGBANK_PROT_EN
    chk("prot_hresp", 32'(hresp0), 32'd1);
    repeat (2) @(negedge clk);
    chk("prot_reg7", regs0[7*32 +: 32], 32'd0);
`else
    chk("prot_hresp", 32'(hresp0), 32'd0);
    @(negedge clk);
    chk("prot_reg7", regs0[7*32 +: 32], 32'h5555AAAA);
`endif
    hwdata = '0;
    @(negedge clk);

    // Three wait states: write reg 4 then immediate read
    bus(1'b0, 1'b1, 32'h10, 1'b1, 3'd2);
    @(negedge clk);
    idle();
    hwdata = 32'h0BADF00D;
    n_low = 1;
    for (int k = 0; k < 10; k++) begin
      if (hready3) break;
      @(negedge clk);
      if (hready3) break;
      n_low++;
    end
    chk("ws_wr_low", 32'(n_low), 32'd3);
    chk("ws_wr_hresp", 32'(hresp3), 32'd0);
    bus(1'b0, 1'b1, 32'h10, 1'b0, 3'd2);
    @(negedge clk);
    idle();
    hwdata = '0;
    chk("ws_rd_first_low", 32'(hready3), 32'd0);
    n_low = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (hready3) break;
      n_low++;
    end
    chk("ws_rd_low",    32'(n_low), 32'd3);
    chk("ws_rd_hrdata", hrdata3,    32'h0BADF00D);
    @(negedge clk);
    chk("ws_idle_hrdata", hrdata3, 32'd0);

    // Reset in WAIT mid-write aborts without commit
    bus(1'b0, 1'b1, 32'h14, 1'b1, 3'd2);
    @(negedge clk);
    idle();
    chk("rstw_wait_hready", 32'(hready3), 32'd0);
    hwdata = 32'hA5A5A5A5;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_hready", 32'(hready3), 32'd1);
    chk("rstw_hresp",  32'(hresp3),  32'd0);
    repeat (4) @(negedge clk);
    hwdata = '0;
    chk("rstw_reg5", regs3[5*32 +: 32], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
